freq_gate_ctrl: RTL and testbench

Measurement sequencer for the frequency meter. Synchronises the external test signal, counts its rising edges over a fixed gate window, and latches the result into a held, saturated 23-bit value. That value drives the binary-to-7-segment display converter input directly. Free-running while `enable` is high; each completed window is flagged with a one-cycle `valid` pulse.

---
 rtl/freq_gate_ctrl.sv | 150 +++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: frequency meter measurement sequencer.
// Synchronises sig_in and counts its rising edges over a GATE_CYCLES window.
// Each completed window latches a held, saturated count for the 7-segment
// converter and flags it with a one-cycle valid pulse.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   sig_in      in   signal under test, asynchronous to clk
//   enable      in   run continuous measurements while high
//   freq_out    out  last latched count, saturated at MAX_COUNT
//   over        out  last latched window exceeded MAX_COUNT
//   valid       out  one-cycle pulse when freq_out/over update
//   gate_active out  high while the gate window is open
module freq_gate_ctrl #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned MAX_COUNT   = 999_999,
  parameter int unsigned WIDTH       = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] freq_out,
  output logic             over,
  output logic             valid,
  output logic             gate_active
);

  localparam int unsigned      TW         = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] CNT_SAT    = WIDTH'(MAX_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  state_e           state_q;
  logic             s1_q;
  logic             s2_q;
  logic             s3_q;
  logic             rise_c;
  logic [TW-1:0]    timer_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_inc_c;
  logic [WIDTH-1:0] freq_q;
  logic             over_q;
  logic             valid_q;
  logic             gate_q;

  // Two-flop synchroniser followed by an edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_c = s2_q & ~s3_q;

  // Counter parks at MAX_COUNT+1 so overflow stays visible without wrapping
  always_comb begin
    count_inc_c = count_q;
    if (rise_c && (count_q < CNT_SAT)) begin
      count_inc_c = count_q + WIDTH'(1);
    end
  end

  // Sequencer: gate window, latch cycle, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      count_q <= '0;
      freq_q  <= '0;
      over_q  <= 1'b0;
      valid_q <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          count_q <= '0;
          if (enable) begin
            state_q <= ST_GATE;
            gate_q  <= 1'b1;
          end
        end

        ST_GATE: begin
          if (!enable) begin
            // Abort: previous result stays on the display
            state_q <= ST_IDLE;
            gate_q  <= 1'b0;
            timer_q <= '0;
            count_q <= '0;
          end else begin
            // A rise in the final gate cycle still counts
            count_q <= count_inc_c;
            if (timer_q == TIMER_LAST) begin
              state_q <= ST_LATCH;
              gate_q  <= 1'b0;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end

        ST_LATCH: begin
          // Rises arriving in this cycle are dropped: one dead cycle per window
          freq_q  <= (count_q > CNT_MAX) ? CNT_MAX : count_q;
          over_q  <= (count_q > CNT_MAX);
          valid_q <= 1'b1;
          timer_q <= '0;
          count_q <= '0;
          if (enable) begin
            state_q <= ST_GATE;
            gate_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            gate_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          gate_q  <= 1'b0;
          timer_q <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign freq_out    = freq_q;
  assign over        = over_q;
  assign valid       = valid_q;
  assign gate_active = gate_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl with a 100-cycle gate window.
// Two instances share all inputs: one with the default MAX_COUNT and one with
// MAX_COUNT=5 for saturation. Expected results per window are queued when a
// phase starts and popped whenever a DUT raises valid.
module tb_freq_gate_ctrl;

  localparam int unsigned G      = 100;
  localparam int unsigned PERIOD = G + 1;
  localparam int unsigned OVF_MAX = 5;

  typedef struct {
    logic [22:0] f;
    logic        o;
    int unsigned e;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sig_in;
  logic        enable;
  logic [22:0] freq_a;
  logic        over_a;
  logic        valid_a;
  logic        gate_a;
  logic [22:0] freq_b;
  logic        over_b;
  logic        valid_b;
  logic        gate_b;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned edge_n;
  int unsigned base;
  exp_t        q_main[$];
  exp_t        q_ovf[$];

  freq_gate_ctrl #(.GATE_CYCLES(G), .MAX_COUNT(999_999), .WIDTH(23)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .freq_out(freq_a), .over(over_a), .valid(valid_a), .gate_active(gate_a)
  );

  freq_gate_ctrl #(.GATE_CYCLES(G), .MAX_COUNT(OVF_MAX), .WIDTH(23)) dut_ovf (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .freq_out(freq_b), .over(over_b), .valid(valid_b), .gate_active(gate_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_freq"},     32'(freq_a),  32'(0));
    chk({pfx, "_over"},     32'(over_a),  32'(0));
    chk({pfx, "_valid"},    32'(valid_a), 32'(0));
    chk({pfx, "_gate"},     32'(gate_a),  32'(0));
    chk({pfx, "_ovf_freq"}, 32'(freq_b),  32'(0));
    chk({pfx, "_ovf_over"}, 32'(over_b),  32'(0));
    chk({pfx, "_ovf_valid"},32'(valid_b), 32'(0));
    chk({pfx, "_ovf_gate"}, 32'(gate_b),  32'(0));
  endtask

  // sig_in value at tick t of each phase (tick t is driven before edge E_t)
  function automatic logic pat(input int ph, input int t);
    case (ph)
      1:       return (t < 310) ? ((t % 10) < 5) : (((t - 310) % 40) < 20);
      2:       return (t % 10) < 5;
      default: return (t == 98) || (t == 200) || (t == 202) || (t >= 250);
    endcase
  endfunction

  // Window k's result is visible right after edge E(101*(k+1))
  task automatic expect_win(input int unsigned k, input int unsigned cnt);
    exp_t e;
    e.e = base + PERIOD * (k + 1);
    e.f = 23'(cnt);
    e.o = 1'b0;
    q_main.push_back(e);
    e.f = 23'((cnt > OVF_MAX) ? OVF_MAX : cnt);
    e.o = (cnt > OVF_MAX);
    q_ovf.push_back(e);
  endtask

  // Reset, then release with enable high; the next posedge is E0
  task automatic start_phase(input int ph);
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    #1;
    chk_zero("rst");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    sig_in = pat(ph, 0);
    base   = edge_n + 1;
  endtask

  // Scoreboard monitor, sampled 1 ns after the active edge
  always @(posedge clk) begin
    exp_t em;
    #1;
    if (valid_a) begin
      if (q_main.size() == 0) begin
        chk("main_spurious_valid", 32'(valid_a), 32'(0));
      end else begin
        em = q_main.pop_front();
        chk("main_freq", 32'(freq_a), 32'(em.f));
        chk("main_over", 32'(over_a), 32'(em.o));
        chk("main_edge", edge_n, em.e);
      end
    end
    if (valid_b) begin
      if (q_ovf.size() == 0) begin
        chk("ovf_spurious_valid", 32'(valid_b), 32'(0));
      end else begin
        em = q_ovf.pop_front();
        chk("ovf_freq", 32'(freq_b), 32'(em.f));
        chk("ovf_over", 32'(over_b), 32'(em.o));
        chk("ovf_edge", edge_n, em.e);
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    edge_n = 0;
    base   = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;

    // Phase 1: period-10 square for three windows, then period 40
    start_phase(1);
    expect_win(0, 10);
    expect_win(1, 10);
    expect_win(2, 10);
    expect_win(3, 3);
    expect_win(4, 2);
    for (int t = 1; t <= 512; t++) begin
      @(negedge clk);
      sig_in = pat(1, t);
    end

    // Phase 2: one result of 10, abort at timer 50, re-arm, reset at timer 60
    start_phase(2);
    expect_win(0, 10);
    for (int t = 1; t <= 221; t++) begin
      @(negedge clk);
      if (t == 152) chk("abort_gate_before", 32'(gate_a), 32'(1));
      if (t == 153) chk("abort_gate_after",  32'(gate_a), 32'(0));
      if (t == 158) begin
        chk("abort_hold_freq",     32'(freq_a), 32'(10));
        chk("abort_hold_over",     32'(over_a), 32'(0));
        chk("abort_hold_ovf_freq", 32'(freq_b), 32'(5));
        chk("abort_hold_ovf_over", 32'(over_b), 32'(1));
      end
      if (t == 221) begin
        chk("midgate_gate", 32'(gate_a), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
      end else begin
        enable = (t < 152) || (t >= 160);
        sig_in = pat(2, t);
      end
    end

    // Phase 3: single pulses at the window boundaries, then sig_in held high
    start_phase(3);
    expect_win(0, 1);
    expect_win(1, 0);
    expect_win(2, 2);
    expect_win(3, 0);
    expect_win(4, 0);
    for (int t = 1; t <= 512; t++) begin
      @(negedge clk);
      sig_in = pat(3, t);
    end

    chk("main_queue_drained", 32'(q_main.size()), 32'(0));
    chk("ovf_queue_drained",  32'(q_ovf.size()),  32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
